avr_sreg_seq: RTL and testbench
===============================

// Module: avr_sreg_seq
// PURPOSE
//   Status register (SREG) and word-op sequencer around the AVR ALU.
//   - Generates the second-cycle strobes adiw_st/sbiw_st that feed the ALU.
//   - Holds SREG {I,T,H,S,V,N,Z,C} and merges ALU flag results into it, per-class masked.
//   - Applies BSET/BCLR/BST, RETI, interrupt acknowledge and I/O writes at 0x3F.
//   - Feeds SREG back as the ALU carry/zero inputs and drives the interrupt-enable gate.
// PARAMETERS
//   SREG_ADR   6'h3F   I/O address of SREG
//   RST_VAL    8'h00   SREG value after reset
// PORTS
//   cp2         in   1  core clock, all state updates on rising edge
//   rst         in   1  asynchronous reset, active-high
//   cp2en       in   1  clock enable; no state changes when 0
//   alu_flags   in   6  {h,s,v,n,z,c} from ALU, same cycle
//   upd_hsvnzc  in   1  ADD/ADC/SUB/SUBI/SBC/SBCI/CP/CPC/CPI/NEG class
//   upd_svnzc   in   1  COM/LSR/ROR/ASR class
//   upd_svnz    in   1  AND/ANDI/OR/ORI/EOR/INC/DEC class
//   idc_adiw    in   1  ADIW first cycle
//   idc_sbiw    in   1  SBIW first cycle
//   idc_bset    in   1  BSET/SEx: set SREG[bit_sel]
//   idc_bclr    in   1  BCLR/CLx: clear SREG[bit_sel]
//   bit_sel     in   3  flag index for BSET/BCLR
//   idc_bst     in   1  BST: T <= bst_bit
//   bst_bit     in   1  selected register-file bit for BST
//   idc_reti    in   1  RETI: sets I
//   irq_ack     in   1  interrupt entry: clears I
//   adr         in   6  I/O address
//   iowe        in   1  I/O write strobe
//   dbus_in     in   8  I/O write data
//   sreg_out    out  8  registered SREG; bits 0/1 go to ALU c/z flag inputs
//   sreg_sel    out  1  combinational, adr==SREG_ADR (for I/O read mux)
//   adiw_st     out  1  ADIW second-cycle strobe to ALU
//   sbiw_st     out  1  SBIW second-cycle strobe to ALU
//   irq_en      out  1  global interrupt enable to interrupt controller
// BEHAVIOUR
//   Reset (async, immediate):
//     sreg_out=RST_VAL; adiw_st=0; sbiw_st=0; irq_en=0; FSM state IDLE.
//   Word-op FSM (IDLE, ADIW2, SBIW2); advances only on edges with cp2en=1:
//     IDLE  -> ADIW2 on idc_adiw; IDLE -> SBIW2 on idc_sbiw (idc_adiw wins if both).
//     ADIW2/SBIW2 -> IDLE on the next enabled edge, unconditionally.
//     adiw_st = state==ADIW2; sbiw_st = state==SBIW2 (registered, 1 cycle wide when cp2en=1).
//     With cp2en=0 the strobe holds until the next enabled edge.
//     idc_adiw/idc_sbiw seen while in ADIW2/SBIW2 are ignored (decoder must not issue them).
//   Flag update, applied at the enabled edge. Priority, highest first; lower sources are
//   merged only into bits not written by a higher source:
//     1 irq_ack: I<=0.
//     2 iowe & adr==SREG_ADR: all 8 bits <= dbus_in.
//     3 idc_bset/idc_bclr: SREG[bit_sel] <= 1/0 (bset wins if both).
//     4 idc_reti: I<=1.
//     5 idc_bst: T<=bst_bit.
//     6 ALU classes (from alu_flags):
//         upd_hsvnzc    -> H,S,V,N,Z,C
//         upd_svnzc     -> S,V,N,Z,C
//         upd_svnz      -> S,V,N,Z
//         idc_adiw/sbiw -> Z,C (first byte)
//         adiw_st/sbiw_st -> S,V,N,Z,C (ALU supplies chained Z)
//   Bits not targeted by any active source hold their value.
//   irq_en:
//     cleared on the same edge that I becomes 0;
//     otherwise irq_en <= old I, so after I goes 0->1 it rises one enabled edge later
//     (the instruction after SEI/RETI always executes).
//   Reset mid word-op aborts the FSM to IDLE with no flag update.
// TESTING
//   T1 rst=1 while SREG=8'hFF, adiw_st=1
//      -> outputs go to 8'h00 / 0 without a clock edge; after release, sreg_out=8'h00.
//   T2 SREG=8'h00; upd_hsvnzc, alu_flags=6'b100011
//      -> sreg_out=8'h23 next cycle; then upd_svnz with alu_flags=0 -> sreg_out=8'h21.
//   T3 idc_adiw pulse with cp2en=1
//      -> adiw_st=1 exactly on the next cycle; with cp2en=0 for 3 cycles after,
//         adiw_st held 1 until cp2en returns, then 0.
//   T4 idc_bset bit_sel=7
//      -> sreg_out[7]=1 next edge, irq_en=1 one enabled edge later;
//         irq_ack on that cycle -> I=0 and irq_en=0 same edge.
//   T5 same cycle: iowe, adr=6'h3F, dbus_in=8'h80, irq_ack=1 and upd_hsvnzc
//      -> sreg_out=8'h00 (irq_ack clears I; I/O write blocks ALU).
//   T6 SREG T=0, idc_bst with bst_bit=1 and upd_svnz with alu_flags z=1
//      -> sreg_out=8'h42.

Source files
------------

// File: rtl/avr_sreg_seq.sv
// ----------------------------------------------------------------------------
// avr_sreg_seq
//   AVR status register (SREG {I,T,H,S,V,N,Z,C}) and the word-op (ADIW/SBIW)
//   second-cycle sequencer that sits next to the ALU.
//
// Ports
//   cp2, rst          core clock, asynchronous active-high reset
//   cp2en             clock enable; no state changes when low
//   alu_flags         {h,s,v,n,z,c} from the ALU for the current instruction
//   upd_hsvnzc/svnzc/svnz   ALU flag-update class selects
//   idc_adiw/idc_sbiw first cycle of a word op
//   idc_bset/idc_bclr/bit_sel   set/clear a single SREG bit
//   idc_bst/bst_bit   load T from the register file
//   idc_reti          set I on return from interrupt
//   irq_ack           clear I on interrupt entry
//   adr/iowe/dbus_in  I/O write port; SREG lives at SREG_ADR
//   sreg_out          registered SREG (bits 1:0 feed the ALU z/c inputs)
//   sreg_sel          combinational address match for the I/O read mux
//   adiw_st/sbiw_st   registered second-cycle strobes to the ALU
//   irq_en            registered global interrupt enable
// ----------------------------------------------------------------------------
module avr_sreg_seq #(
    parameter logic [5:0] SREG_ADR = 6'h3F,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic       cp2,
    input  logic       rst,
    input  logic       cp2en,
    input  logic [5:0] alu_flags,
    input  logic       upd_hsvnzc,
    input  logic       upd_svnzc,
    input  logic       upd_svnz,
    input  logic       idc_adiw,
    input  logic       idc_sbiw,
    input  logic       idc_bset,
    input  logic       idc_bclr,
    input  logic [2:0] bit_sel,
    input  logic       idc_bst,
    input  logic       bst_bit,
    input  logic       idc_reti,
    input  logic       irq_ack,
    input  logic [5:0] adr,
    input  logic       iowe,
    input  logic [7:0] dbus_in,
    output logic [7:0] sreg_out,
    output logic       sreg_sel,
    output logic       adiw_st,
    output logic       sbiw_st,
    output logic       irq_en
);

    localparam int unsigned ALU_W  = 6;
    localparam int unsigned BIT_T  = 6;
    localparam int unsigned BIT_I  = 7;

    // ALU flag-class masks over SREG[5:0] = {H,S,V,N,Z,C}
    localparam logic [ALU_W-1:0] MASK_HSVNZC = 6'h3F;
    localparam logic [ALU_W-1:0] MASK_SVNZC  = 6'h1F;
    localparam logic [ALU_W-1:0] MASK_SVNZ   = 6'h1E;
    localparam logic [ALU_W-1:0] MASK_ZC     = 6'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADIW2 = 2'd1,
        SBIW2 = 2'd2
    } state_t;

    state_t           state;
    logic [ALU_W-1:0] alu_mask;
    logic [7:0]       sreg_nxt;

    // I/O read-mux select
    assign sreg_sel = (adr == SREG_ADR);

    // Next SREG: lowest-priority source first, higher sources overwrite
    always_comb begin
        alu_mask = '0;
        if (upd_hsvnzc)            alu_mask = alu_mask | MASK_HSVNZC;
        if (upd_svnzc)             alu_mask = alu_mask | MASK_SVNZC;
        if (upd_svnz)              alu_mask = alu_mask | MASK_SVNZ;
        if (idc_adiw || idc_sbiw)  alu_mask = alu_mask | MASK_ZC;
        if (adiw_st || sbiw_st)    alu_mask = alu_mask | MASK_SVNZC;

        sreg_nxt      = sreg_out;
        sreg_nxt[5:0] = (sreg_out[5:0] & ~alu_mask) | (alu_flags & alu_mask);

        if (idc_bst)  sreg_nxt[BIT_T] = bst_bit;
        if (idc_reti) sreg_nxt[BIT_I] = 1'b1;

        if (idc_bset)      sreg_nxt[bit_sel] = 1'b1;
        else if (idc_bclr) sreg_nxt[bit_sel] = 1'b0;

        if (iowe && sreg_sel) sreg_nxt = dbus_in;

        if (irq_ack) sreg_nxt[BIT_I] = 1'b0;
    end

    // SREG, interrupt enable and word-op sequencer
    always_ff @(posedge cp2 or posedge rst) begin
        if (rst) begin
            sreg_out <= RST_VAL;
            irq_en   <= 1'b0;
            state    <= IDLE;
            adiw_st  <= 1'b0;
            sbiw_st  <= 1'b0;
        end else if (cp2en) begin
            sreg_out <= sreg_nxt;
            // Drops with I; rises one edge after I so the next instruction runs
            irq_en   <= sreg_out[BIT_I] & sreg_nxt[BIT_I];

            case (state)
                IDLE: begin
                    if (idc_adiw) begin
                        state   <= ADIW2;
                        adiw_st <= 1'b1;
                        sbiw_st <= 1'b0;
                    end else if (idc_sbiw) begin
                        state   <= SBIW2;
                        adiw_st <= 1'b0;
                        sbiw_st <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        adiw_st <= 1'b0;
                        sbiw_st <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    adiw_st <= 1'b0;
                    sbiw_st <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_sreg_seq.sv
// ----------------------------------------------------------------------------
// tb_avr_sreg_seq
//   Directed bench for avr_sreg_seq: linear steps with hand-computed
//   expected SREG / strobe / interrupt-enable values.
// ----------------------------------------------------------------------------
module tb_avr_sreg_seq;

    logic       cp2;
    logic       rst;
    logic       cp2en;
    logic [5:0] alu_flags;
    logic       upd_hsvnzc;
    logic       upd_svnzc;
    logic       upd_svnz;
    logic       idc_adiw;
    logic       idc_sbiw;
    logic       idc_bset;
    logic       idc_bclr;
    logic [2:0] bit_sel;
    logic       idc_bst;
    logic       bst_bit;
    logic       idc_reti;
    logic       irq_ack;
    logic [5:0] adr;
    logic       iowe;
    logic [7:0] dbus_in;
    logic [7:0] sreg_out;
    logic       sreg_sel;
    logic       adiw_st;
    logic       sbiw_st;
    logic       irq_en;

    int n_tests = 0;
    int n_fail  = 0;

    avr_sreg_seq dut (
        .cp2        (cp2),
        .rst        (rst),
        .cp2en      (cp2en),
        .alu_flags  (alu_flags),
        .upd_hsvnzc (upd_hsvnzc),
        .upd_svnzc  (upd_svnzc),
        .upd_svnz   (upd_svnz),
        .idc_adiw   (idc_adiw),
        .idc_sbiw   (idc_sbiw),
        .idc_bset   (idc_bset),
        .idc_bclr   (idc_bclr),
        .bit_sel    (bit_sel),
        .idc_bst    (idc_bst),
        .bst_bit    (bst_bit),
        .idc_reti   (idc_reti),
        .irq_ack    (irq_ack),
        .adr        (adr),
        .iowe       (iowe),
        .dbus_in    (dbus_in),
        .sreg_out   (sreg_out),
        .sreg_sel   (sreg_sel),
        .adiw_st    (adiw_st),
        .sbiw_st    (sbiw_st),
        .irq_en     (irq_en)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    task automatic tick();
        @(posedge cp2);
        #1;
    endtask

    task automatic idle_inputs();
        cp2en      = 1'b1;
        alu_flags  = '0;
        upd_hsvnzc = 1'b0;
        upd_svnzc  = 1'b0;
        upd_svnz   = 1'b0;
        idc_adiw   = 1'b0;
        idc_sbiw   = 1'b0;
        idc_bset   = 1'b0;
        idc_bclr   = 1'b0;
        bit_sel    = '0;
        idc_bst    = 1'b0;
        bst_bit    = 1'b0;
        idc_reti   = 1'b0;
        irq_ack    = 1'b0;
        adr        = '0;
        iowe       = 1'b0;
        dbus_in    = '0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_sreg", sreg_out, 8'h00);
        check("reset_irq_en", 8'(irq_en), 8'h00);
        check("reset_adiw_st", 8'(adiw_st), 8'h00);

        // T1: load FF and start ADIW, then async reset between edges
        iowe = 1'b1; adr = 6'h3F; dbus_in = 8'hFF; idc_adiw = 1'b1;
        tick();
        idle_inputs();
        check("t1_sreg_ff", sreg_out, 8'hFF);
        check("t1_adiw_st", 8'(adiw_st), 8'h01);
        adr = 6'h3F; #1;
        check("sreg_sel_hit", 8'(sreg_sel), 8'h01);
        adr = 6'h3E; #1;
        check("sreg_sel_miss", 8'(sreg_sel), 8'h00);
        rst = 1'b1; #1;
        check("t1_async_sreg", sreg_out, 8'h00);
        check("t1_async_adiw", 8'(adiw_st), 8'h00);
        check("t1_async_irq_en", 8'(irq_en), 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("t1_after_release", sreg_out, 8'h00);

        // T2: ALU class merges
        upd_hsvnzc = 1'b1; alu_flags = 6'b100011;
        tick();
        idle_inputs();
        check("t2_hsvnzc", sreg_out, 8'h23);
        upd_svnz = 1'b1; alu_flags = 6'b000000;
        tick();
        idle_inputs();
        check("t2_svnz", sreg_out, 8'h21);
        upd_svnzc = 1'b1; alu_flags = 6'b111110;
        tick();
        idle_inputs();
        check("t2_svnzc", sreg_out, 8'h3E);
        upd_svnzc = 1'b1; alu_flags = 6'b000001;
        tick();
        idle_inputs();
        check("t2_svnzc_b", sreg_out, 8'h21);

        // T3: ADIW strobe, held across disabled cycles; first cycle writes Z,C
        idc_adiw = 1'b1;
        tick();
        idle_inputs();
        check("t3_adiw_st", 8'(adiw_st), 8'h01);
        check("t3_sreg_zc", sreg_out, 8'h20);
        cp2en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            upd_hsvnzc = 1'b1; alu_flags = 6'h3F;
            tick();
            check("t3_hold_adiw", 8'(adiw_st), 8'h01);
            check("t3_hold_sreg", sreg_out, 8'h20);
        end
        idle_inputs();
        alu_flags = 6'b000110;
        tick();
        idle_inputs();
        check("t3_adiw_done", 8'(adiw_st), 8'h00);
        check("t3_second_flags", sreg_out, 8'h26);
        idc_sbiw = 1'b1;
        tick();
        idle_inputs();
        check("t3_sbiw_st", 8'(sbiw_st), 8'h01);
        check("t3_sbiw_adiw", 8'(adiw_st), 8'h00);
        tick();
        check("t3_sbiw_done", 8'(sbiw_st), 8'h00);
        check("t3_sbiw_sreg", sreg_out, 8'h20);
        idc_adiw = 1'b1; idc_sbiw = 1'b1;
        tick();
        idle_inputs();
        check("t3_both_adiw", 8'(adiw_st), 8'h01);
        check("t3_both_sbiw", 8'(sbiw_st), 8'h00);
        tick();
        check("t3_both_sreg", sreg_out, 8'h20);

        // T4: SEI path, irq_en lag, irq_ack clears both on one edge
        idc_bset = 1'b1; bit_sel = 3'd7;
        tick();
        idle_inputs();
        check("t4_sei_sreg", sreg_out, 8'hA0);
        check("t4_irq_en_lag", 8'(irq_en), 8'h00);
        tick();
        check("t4_irq_en_on", 8'(irq_en), 8'h01);
        irq_ack = 1'b1;
        tick();
        idle_inputs();
        check("t4_ack_sreg", sreg_out, 8'h20);
        check("t4_ack_irq_en", 8'(irq_en), 8'h00);
        idc_reti = 1'b1;
        tick();
        idle_inputs();
        check("t4_reti_sreg", sreg_out, 8'hA0);
        check("t4_reti_lag", 8'(irq_en), 8'h00);
        tick();
        check("t4_reti_on", 8'(irq_en), 8'h01);
        idc_bclr = 1'b1; bit_sel = 3'd7;
        tick();
        idle_inputs();
        check("t4_cli_sreg", sreg_out, 8'h20);
        check("t4_cli_irq_en", 8'(irq_en), 8'h00);
        idc_bclr = 1'b1; bit_sel = 3'd5;
        tick();
        idle_inputs();
        check("t4_clh", sreg_out, 8'h00);
        idc_bset = 1'b1; idc_bclr = 1'b1; bit_sel = 3'd2;
        tick();
        idle_inputs();
        check("t4_bset_wins", sreg_out, 8'h04);
        idc_bclr = 1'b1; bit_sel = 3'd2; upd_svnz = 1'b1; alu_flags = 6'b000100;
        tick();
        idle_inputs();
        check("t4_bclr_over_alu", sreg_out, 8'h00);

        // T5: irq_ack over I/O write, I/O write over ALU
        iowe = 1'b1; adr = 6'h3F; dbus_in = 8'h80; irq_ack = 1'b1;
        upd_hsvnzc = 1'b1; alu_flags = 6'h3F;
        tick();
        idle_inputs();
        check("t5_sreg", sreg_out, 8'h00);
        iowe = 1'b1; adr = 6'h3E; dbus_in = 8'hFF;
        tick();
        idle_inputs();
        check("t5_other_adr", sreg_out, 8'h00);

        // T6: BST and ALU class on disjoint bits
        idc_bst = 1'b1; bst_bit = 1'b1; upd_svnz = 1'b1; alu_flags = 6'b000010;
        tick();
        idle_inputs();
        check("t6_sreg", sreg_out, 8'h42);

        // Disabled edge: nothing changes
        cp2en = 1'b0; upd_hsvnzc = 1'b1; alu_flags = 6'h3F; idc_bset = 1'b1; bit_sel = 3'd7;
        tick();
        idle_inputs();
        check("hold_sreg", sreg_out, 8'h42);
        check("hold_irq_en", 8'(irq_en), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
